// File: rtl/seq_pkg.sv
// Shared constants for the birthday-sequence link (transmitter and receiver).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_pkg;

   // Transmitter FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   // Default pattern shared with the sequence receiver
   localparam logic [7:0] BDAY_PATTERN = 8'b1110_1101;

   // Line level while idle or in an inter-repetition gap
   localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/seq_transmitter_if.sv
// Request handshake plus serial line of the sequence transmitter.
// Latency: n/a (wires only).
// Backpressure: o_ready low while a frame is in flight; requests are not queued.
interface seq_transmitter_if #(
   parameter int WIDTH = 8
);
   import seq_pkg::*;

   logic             i_valid;
   logic [WIDTH-1:0] i_data;
   logic [3:0]       i_repeat;
   logic             o_ready;
   logic             o_bit_seq;
   logic             o_busy;
   logic             o_done;

   modport master (
      output i_valid, i_data, i_repeat,
      input  o_ready, o_bit_seq, o_busy, o_done
   );

   modport slave (
      input  i_valid, i_data, i_repeat,
      output o_ready, o_bit_seq, o_busy, o_done
   );

endinterface

// File: rtl/piso_shift.sv
// Parallel-load, shift-left register exposing its MSB.
// Latency: load/shift take effect on the next rising edge.
// Backpressure: none; load has priority over shift.
module piso_shift
   import seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             msb
);

   // Load a new word, or move the next bit up into the MSB
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (load) begin
         q <= din;
      end else if (shift) begin
         q <= {q[WIDTH-2:0], 1'b0};
      end
   end

   assign msb = q[WIDTH-1];

endmodule

// File: rtl/seq_transmitter.sv
// Serial pattern transmitter: word sent MSB-first, repeated with idle gaps.
// Latency: first bit on the line the cycle after acceptance; done one cycle after the last bit.
// Backpressure: o_ready only in IDLE; requests during SEND/GAP are ignored, not queued.
module seq_transmitter
   import seq_pkg::*;
#(
   parameter int   WIDTH    = 8,
   parameter int   GAP_LEN  = 2,
   parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
   input  logic              i_clk,
   input  logic              i_rst,
   seq_transmitter_if.slave  bus
);

   localparam int BW = $clog2(WIDTH);
   // A zero-length gap still needs a one-bit counter to keep the declaration legal
   localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LAST = (GAP_LEN > 0) ? GW'(GAP_LEN - 1) : '0;

   logic [1:0]       state;
   logic [BW-1:0]    bit_cnt;
   logic [GW-1:0]    gap_cnt;
   logic [3:0]       rep_cnt;
   logic [WIDTH-1:0] word;
   logic             bit_seq;
   logic             busy;
   logic             done;

   logic             accept;
   logic             word_end;
   logic             reload;
   logic             gap_end;
   logic             sr_load;
   logic             sr_shift;
   logic [WIDTH-1:0] sr_din;
   logic [WIDTH-1:0] sr_q;
   logic             sr_msb;

   assign accept   = (state == ST_IDLE) && bus.i_valid;
   assign word_end = (state == ST_SEND) && (bit_cnt == BIT_LAST);
   assign reload   = word_end && (rep_cnt != 4'd0);
   assign gap_end  = (state == ST_GAP) && (gap_cnt == GAP_LAST);
   assign sr_load  = accept || reload;
   assign sr_shift = (state == ST_SEND) && !word_end;
   assign sr_din   = accept ? bus.i_data : word;

   piso_shift #(
      .WIDTH (WIDTH)
   ) u_piso (
      .clk   (i_clk),
      .rst   (i_rst),
      .load  (sr_load),
      .shift (sr_shift),
      .din   (sr_din),
      .q     (sr_q),
      .msb   (sr_msb)
   );

   // Control FSM with bit, gap and repetition counters
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         gap_cnt <= '0;
         rep_cnt <= '0;
         word    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  word    <= bus.i_data;
                  rep_cnt <= bus.i_repeat;
                  bit_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (word_end) begin
                  bit_cnt <= '0;
                  if (rep_cnt == 4'd0) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     rep_cnt <= rep_cnt - 4'd1;
                     gap_cnt <= '0;
                     if (GAP_LEN != 0) begin
                        state <= ST_GAP;
                     end
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_end) begin
                  gap_cnt <= '0;
                  state   <= ST_SEND;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Registered line: load the bit that will be on the wire during the next cycle.
   // The shift register MSB is the bit currently on the line, so the next one is q[WIDTH-2].
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         bit_seq <= IDLE_BIT;
      end else if (accept) begin
         bit_seq <= bus.i_data[WIDTH-1];
      end else if (state == ST_SEND) begin
         if (word_end) begin
            if ((rep_cnt != 4'd0) && (GAP_LEN == 0)) begin
               bit_seq <= word[WIDTH-1];
            end else begin
               bit_seq <= IDLE_BIT;
            end
         end else begin
            bit_seq <= sr_q[WIDTH-2];
         end
      end else if (gap_end) begin
         bit_seq <= sr_msb;
      end else begin
         bit_seq <= IDLE_BIT;
      end
   end

   assign bus.o_ready   = (state == ST_IDLE);
   assign bus.o_bit_seq = bit_seq;
   assign bus.o_busy    = busy;
   assign bus.o_done    = done;

endmodule

// File: tb/tb_seq_transmitter.sv
// Directed bench for seq_transmitter: reset, framing, gaps, busy rejection, back-to-back, mid-frame reset, pattern loopback.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_transmitter;
   import seq_pkg::*;

   localparam int WIDTH   = 8;
   localparam int GAP_LEN = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   int         n_cmp = 0;
   int         n_err = 0;
   int         det_cnt = 0;
   logic [7:0] win = 8'h00;

   seq_transmitter_if #(.WIDTH(WIDTH)) bus ();

   seq_transmitter #(
      .WIDTH    (WIDTH),
      .GAP_LEN  (GAP_LEN),
      .IDLE_BIT (1'b0)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected line level i cycles into a frame (0-based)
   function automatic logic exp_bit(input logic [7:0] d, input int i);
      int pos;
      pos = i % (WIDTH + GAP_LEN);
      return (pos < WIDTH) ? d[WIDTH-1-pos] : 1'b0;
   endfunction

   // Request must already be driven before the accepting edge; checks the whole frame and the done cycle.
   task automatic expect_frame(input string name, input logic [7:0] d, input logic [3:0] rep, input bit junk);
      int r;
      int n;
      r = int'(rep);
      n = (r + 1) * WIDTH + r * GAP_LEN;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) begin
            bus.i_valid  = junk;
            bus.i_data   = ~d;
            bus.i_repeat = 4'd0;
         end
         check_eq($sformatf("%s bit[%0d]", name, i), 32'(bus.o_bit_seq), 32'(exp_bit(d, i)));
         check_eq($sformatf("%s busy[%0d]", name, i), 32'(bus.o_busy), 32'd1);
         check_eq($sformatf("%s ready[%0d]", name, i), 32'(bus.o_ready), 32'd0);
         check_eq($sformatf("%s done[%0d]", name, i), 32'(bus.o_done), 32'd0);
         win = {win[6:0], bus.o_bit_seq};
         if (win == BDAY_PATTERN) det_cnt++;
      end
      @(negedge clk);
      bus.i_valid = 1'b0;
      check_eq({name, " done_pulse"}, 32'(bus.o_done), 32'd1);
      check_eq({name, " done_ready"}, 32'(bus.o_ready), 32'd1);
      check_eq({name, " done_busy"}, 32'(bus.o_busy), 32'd0);
      check_eq({name, " done_line"}, 32'(bus.o_bit_seq), 32'd0);
   endtask

   task automatic drive_req(input logic [7:0] d, input logic [3:0] rep);
      bus.i_valid  = 1'b1;
      bus.i_data   = d;
      bus.i_repeat = rep;
   endtask

   initial begin
      // Reset held with a pending request
      bus.i_valid  = 1'b1;
      bus.i_data   = 8'hFF;
      bus.i_repeat = 4'd0;
      rst          = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_eq("rst line", 32'(bus.o_bit_seq), 32'd0);
         check_eq("rst ready", 32'(bus.o_ready), 32'd1);
         check_eq("rst busy", 32'(bus.o_busy), 32'd0);
         check_eq("rst done", 32'(bus.o_done), 32'd0);
      end
      bus.i_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst no_accept", 32'(bus.o_busy), 32'd0);

      // Single word
      drive_req(8'b1110_1101, 4'd0);
      expect_frame("single", 8'b1110_1101, 4'd0, 1'b0);
      @(negedge clk);
      check_eq("single idle_line", 32'(bus.o_bit_seq), 32'd0);
      check_eq("single done_clear", 32'(bus.o_done), 32'd0);

      // Repetitions with gaps
      drive_req(8'hA5, 4'd2);
      expect_frame("repgap", 8'hA5, 4'd2, 1'b0);

      // Requests held during a frame are ignored; next word chained on the done cycle
      @(negedge clk);
      drive_req(8'h3C, 4'd1);
      expect_frame("reject", 8'h3C, 4'd1, 1'b1);
      drive_req(8'hED, 4'd0);
      expect_frame("b2b", 8'hED, 4'd0, 1'b0);

      // Reset during the 4th bit
      @(negedge clk);
      drive_req(8'hF0, 4'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         bus.i_valid = 1'b0;
      end
      @(negedge clk);
      check_eq("midrst bit4", 32'(bus.o_bit_seq), 32'd1);
      #1 rst = 1'b0;
      #1;
      check_eq("midrst line", 32'(bus.o_bit_seq), 32'd0);
      check_eq("midrst busy", 32'(bus.o_busy), 32'd0);
      check_eq("midrst ready", 32'(bus.o_ready), 32'd1);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check_eq("midrst no_done", 32'(bus.o_done), 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      drive_req(8'h96, 4'd1);
      expect_frame("postrst", 8'h96, 4'd1, 1'b0);

      // Birthday pattern twice; a window detector on the line must fire once per repetition
      @(negedge clk);
      det_cnt = 0;
      win     = 8'h00;
      drive_req(BDAY_PATTERN, 4'd1);
      expect_frame("loop", BDAY_PATTERN, 4'd1, 1'b0);
      check_eq("loop detections", 32'(det_cnt), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_transmitter.md
# seq_transmitter

Serial pattern transmitter for the birthday-sequence link. It accepts a WIDTH-bit pattern word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, on a single serial line. It can repeat the word a programmable number of times, with idle gap bits between repetitions. It drives the sequence receiver's bit input, either in the system path or as a synthesizable stimulus source for receiver benches.

## Interface
- WIDTH, 8: pattern word length in bits (≥2).
- GAP_LEN, 2: idle bits inserted between repetitions; 0 means back-to-back repetitions with no gap.
- IDLE_BIT, 1'b0: line level driven while idle or in a gap.
- i_clk  input  1  clock; all state changes on its rising edge.
- i_rst  input  1  asynchronous, active-low reset.
- i_valid  input  1  pattern request.
- i_data  input  WIDTH  pattern word; bit WIDTH-1 is sent first.
- i_repeat  input  4  extra repetitions; the word is sent i_repeat+1 times.
- o_ready  output  1  high when a request can be accepted.
- o_bit_seq  output  1  serial data line (registered).
- o_busy  output  1  high while in SEND or GAP.
- o_done  output  1  one-cycle pulse after the last bit of the last repetition.

## Operation
- Reset values (i_rst low, asynchronous): state IDLE, o_bit_seq = IDLE_BIT, o_ready = 1, o_busy = 0, o_done = 0, all counters 0, shift register cleared.
- States: IDLE, SEND, GAP.
- IDLE:
  - o_ready = 1, o_bit_seq = IDLE_BIT.
  - On i_valid && o_ready: latch i_data into the shift register, latch i_repeat into rep_cnt, clear bit_cnt, go to SEND.
- SEND:
  - o_bit_seq = shift register MSB; shift left each cycle; bit_cnt increments from 0 to WIDTH-1.
  - At bit_cnt == WIDTH-1, if rep_cnt == 0: go to IDLE and assert o_done.
  - At bit_cnt == WIDTH-1, if rep_cnt != 0: decrement rep_cnt, reload the shift register from the latched word, then go to GAP. If GAP_LEN == 0, stay in SEND instead.
- GAP:
  - o_bit_seq = IDLE_BIT for exactly GAP_LEN cycles (gap_cnt), then go to SEND.
- Requests during SEND or GAP: o_ready = 0 and i_valid is ignored. Nothing is queued, and the latched word is unaffected.
- Back-to-back: o_done and o_ready are both high in the first IDLE cycle. A request accepted at that edge starts the next word with no extra idle cycle.
- Widths:
  - bit_cnt is $clog2(WIDTH) bits.
  - gap_cnt is $clog2(GAP_LEN+1) bits.
  - rep_cnt is 4 bits and decrements only; no wrap-around is possible.
- Reset mid-operation: the line returns to IDLE_BIT immediately (asynchronously). The frame is abandoned, o_done is not pulsed, and state is IDLE on deassertion.

## Timing
- Request accepted at rising edge k: bit WIDTH-1 is on o_bit_seq during cycle k+1 (after edge k). A receiver samples it at edge k+1.
- One bit per cycle, with no bubbles within a word.
- Total frame length is N = (i_repeat+1)*WIDTH + i_repeat*GAP_LEN cycles, occupying cycles k+1..k+N.
- o_done is high during cycle k+N+1 only, and o_ready is 1 in that same cycle.
- o_busy is high during cycles k+1..k+N.
- o_ready is a function of state only; there is no combinational path from i_valid.
- o_bit_seq, o_busy and o_done are registered outputs.

## Structure
- Shared package seq_pkg holds:
  - the state enum (IDLE, SEND, GAP);
  - BDAY_PATTERN, the 8-bit default pattern constant shared with the receiver;
  - IDLE_BIT_DEFAULT.
- One sub-module, piso_shift: a WIDTH-bit parallel-load, shift-left register exposing its MSB. Its load input is driven by the FSM.
- Counters and the FSM live in seq_transmitter.

## Test plan
- Reset: hold i_rst low for 3 cycles with i_valid = 1 → o_bit_seq = 0, o_ready = 1, o_busy = 0, o_done = 0; no request is accepted.
- Single word: i_data = 8'b1110_1101, i_repeat = 0, accepted at edge k → o_bit_seq = 1,1,1,0,1,1,0,1 in cycles k+1..k+8; o_done pulses in cycle k+9; line then returns to 0.
- Repeat with gap: i_data = 8'hA5, i_repeat = 2, GAP_LEN = 2 → A5 bits, 0,0, A5 bits, 0,0, A5 bits over cycles k+1..k+28; o_done in cycle k+29; o_busy high for 28 cycles.
- Busy rejection and back-to-back:
  - i_valid held high through a frame with different i_data → the output frame is unchanged.
  - The next word is accepted on the o_done cycle; its first bit appears with no idle cycle between frames.
- Reset mid-frame: assert i_rst during the 4th bit → o_bit_seq = 0 immediately, no o_done pulse; after release, a new request transmits correctly.
- Loopback: connect to the sequence receiver and send the birthday pattern with i_repeat = 1 → the receiver's o_seq_detected pulses once per repetition.
